// File: rtl/trace_pkg.sv
// Shared record types and field widths for the commit trace encoder.
// Build option: TRACE_TIMESTAMP_EN adds a capture timestamp to every record.
package trace_pkg;

   localparam logic [1:0] TR_REG   = 2'd0;
   localparam logic [1:0] TR_STORE = 2'd1;
   localparam logic [1:0] TR_LOAD  = 2'd2;
   localparam logic [1:0] TR_BRJ   = 2'd3;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned RD_W    = 5;
   localparam int unsigned VALUE_W = 32;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned TS_W    = 32;

   typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
      logic [TS_W-1:0]    ts;
`endif
      logic [1:0]         rtype;
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic [RD_W-1:0]    rd;
      logic [VALUE_W-1:0] value;
      logic [ADDR_W-1:0]  addr;
   } trace_rec_t;

   localparam int unsigned REC_W = $bits(trace_rec_t);

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

endpackage

// File: rtl/commit_trace_encoder_if.sv
// Trace record stream (valid/ready) between the encoder and a trace sink.
// Build option: TRACE_TIMESTAMP_EN adds the trace_ts field.
interface commit_trace_encoder_if;

   logic        trace_valid;
   logic        trace_ready;
   logic [1:0]  trace_type;
   logic [31:0] trace_pc;
   logic [31:0] trace_instr;
   logic [4:0]  trace_rd;
   logic [31:0] trace_value;
   logic [31:0] trace_addr;
`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] trace_ts;

   modport master (
      output trace_valid, trace_type, trace_pc, trace_instr, trace_rd, trace_value,
             trace_addr, trace_ts,
      input  trace_ready
   );
   modport slave (
      input  trace_valid, trace_type, trace_pc, trace_instr, trace_rd, trace_value,
             trace_addr, trace_ts,
      output trace_ready
   );
`else
   modport master (
      output trace_valid, trace_type, trace_pc, trace_instr, trace_rd, trace_value,
             trace_addr,
      input  trace_ready
   );
   modport slave (
      input  trace_valid, trace_type, trace_pc, trace_instr, trace_rd, trace_value,
             trace_addr,
      output trace_ready
   );
`endif

endinterface

// File: rtl/trace_fifo_mw.sv
// Register FIFO accepting up to three consecutive writes and one read per cycle.
// Callers must never request more writes than DEPTH - count.
module trace_fifo_mw #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [1:0]                wr_cnt,
   input  logic [2:0][WIDTH-1:0]     wr_data,
   input  logic                      rd_en,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      empty,
   output logic                      full,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [AW-1:0]     wr_idx [3];
   logic              pop;

   assign count   = wr_ptr_q - rd_ptr_q;
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop     = rd_en && !empty;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      for (int j = 0; j < 3; j++) begin
         wr_idx[j] = wr_ptr_q[AW-1:0] + AW'(j);
      end
   end

   // Storage is cleared on reset so the head-driven outputs read zero afterwards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int j = 0; j < 3; j++) begin
            if (wr_cnt > 2'(j)) begin
               mem_q[wr_idx[j]] <= wr_data[j];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + (AW+1)'(wr_cnt);
         rd_ptr_q <= rd_ptr_q + (AW+1)'(pop);
      end
   end

endmodule

// File: rtl/commit_trace_encoder.sv
// Commit trace encoder: packs wb/store/branch retirement events into typed records, oldest stage
// first, and streams them out through a multi-write FIFO. Build option: TRACE_TIMESTAMP_EN.
module commit_trace_encoder
   import trace_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  trace_en,
   input  logic                  wb_valid,
   input  logic                  wb_is_load,
   input  logic [31:0]           wb_pc,
   input  logic [31:0]           wb_instr,
   input  logic [4:0]            wb_rd,
   input  logic [31:0]           wb_value,
   input  logic [31:0]           wb_addr,
   input  logic                  st_valid,
   input  logic [31:0]           st_pc,
   input  logic [31:0]           st_instr,
   input  logic [31:0]           st_addr,
   input  logic [31:0]           st_data,
   input  logic                  br_valid,
   input  logic [31:0]           br_pc,
   input  logic [31:0]           br_instr,
   commit_trace_encoder_if.master trace,
   output logic                  overflow,
   output logic [CNT_W-1:0]      drop_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [2:0]          ev_valid;
   trace_rec_t          ev_wb, ev_st, ev_br;
   trace_rec_t [2:0]    slot;
   logic [1:0]          k, n_write, n_drop;
   logic [AW:0]         count, free;
   logic                empty, full;
   trace_rec_t          head;
   logic                overflow_q, overflow_d;
   logic [CNT_W-1:0]    drop_count_q, drop_count_d;
   logic [CNT_W:0]      drop_sum;

`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] ts_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + 32'd1;
      end
   end
`endif

   assign ev_valid = {br_valid, st_valid, wb_valid} & {3{trace_en}};
   assign k        = popcount3(ev_valid);

   always_comb begin
      ev_wb       = '0;
      ev_wb.rtype = wb_is_load ? TR_LOAD : TR_REG;
      ev_wb.pc    = wb_pc;
      ev_wb.instr = wb_instr;
      ev_wb.rd    = wb_rd;
      ev_wb.value = wb_value;
      ev_wb.addr  = wb_is_load ? wb_addr : '0;

      ev_st       = '0;
      ev_st.rtype = TR_STORE;
      ev_st.pc    = st_pc;
      ev_st.instr = st_instr;
      ev_st.value = st_data;
      ev_st.addr  = st_addr;

      ev_br       = '0;
      ev_br.rtype = TR_BRJ;
      ev_br.pc    = br_pc;
      ev_br.instr = br_instr;
`ifdef TRACE_TIMESTAMP_EN
      ev_wb.ts = ts_q;
      ev_st.ts = ts_q;
      ev_br.ts = ts_q;
`endif
   end

   // Pack valid events into consecutive slots, oldest stage in slot 0.
   always_comb begin
      slot = '0;
      case (ev_valid)
         3'b001: slot[0] = ev_wb;
         3'b010: slot[0] = ev_st;
         3'b100: slot[0] = ev_br;
         3'b011: begin
            slot[0] = ev_wb;
            slot[1] = ev_st;
         end
         3'b101: begin
            slot[0] = ev_wb;
            slot[1] = ev_br;
         end
         3'b110: begin
            slot[0] = ev_st;
            slot[1] = ev_br;
         end
         3'b111: begin
            slot[0] = ev_wb;
            slot[1] = ev_st;
            slot[2] = ev_br;
         end
         default: slot = '0;
      endcase
   end

   // Space is judged on the start-of-cycle count; a same-cycle pop frees nothing.
   always_comb begin
      free = full ? '0 : (AW+1)'(DEPTH) - count;
      if ((AW+1)'(k) > free) begin
         n_write = free[1:0];
      end else begin
         n_write = k;
      end
      n_drop = k - n_write;
   end

   always_comb begin
      drop_sum     = {1'b0, drop_count_q} + (CNT_W+1)'(n_drop);
      drop_count_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      overflow_d   = overflow_q | (n_drop != 2'd0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   trace_fifo_mw #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_cnt  (n_write),
      .wr_data (slot),
      .rd_en   (trace.trace_ready),
      .rd_data (head),
      .empty   (empty),
      .full    (full),
      .count   (count)
   );

   assign trace.trace_valid = !empty;
   assign trace.trace_type  = head.rtype;
   assign trace.trace_pc    = head.pc;
   assign trace.trace_instr = head.instr;
   assign trace.trace_rd    = head.rd;
   assign trace.trace_value = head.value;
   assign trace.trace_addr  = head.addr;
`ifdef TRACE_TIMESTAMP_EN
   assign trace.trace_ts    = head.ts;
`endif

   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_commit_trace_encoder.sv
// Self-checking bench for commit_trace_encoder: vector table plus directed overflow/reset cases,
// with a queue of expected records compared as the stream delivers them.
module tb_commit_trace_encoder;

   localparam int DEPTH = 16;
   localparam int CNT_W = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        trace_en, wb_valid, wb_is_load, st_valid, br_valid;
   logic [31:0] wb_pc, wb_instr, wb_value, wb_addr;
   logic [4:0]  wb_rd;
   logic [31:0] st_pc, st_instr, st_addr, st_data, br_pc, br_instr;
   logic        overflow;
   logic [CNT_W-1:0] drop_count;

   commit_trace_encoder_if trace_bus ();

   commit_trace_encoder #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .trace_en   (trace_en),
      .wb_valid   (wb_valid),
      .wb_is_load (wb_is_load),
      .wb_pc      (wb_pc),
      .wb_instr   (wb_instr),
      .wb_rd      (wb_rd),
      .wb_value   (wb_value),
      .wb_addr    (wb_addr),
      .st_valid   (st_valid),
      .st_pc      (st_pc),
      .st_instr   (st_instr),
      .st_addr    (st_addr),
      .st_data    (st_data),
      .br_valid   (br_valid),
      .br_pc      (br_pc),
      .br_instr   (br_instr),
      .trace      (trace_bus),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  t;
      logic [31:0] pc, instr;
      logic [4:0]  rd;
      logic [31:0] value, addr, ts;
   } exp_t;

   typedef struct {
      bit         en, wbv, ld, stv, brv;
      int         n;
      logic [5:0] ty;   // ty[1:0] first record type, ty[3:2] second, ty[5:4] third
   } vec_t;

   exp_t        sb[$];
   logic [1:0]  popped[$];
   vec_t        vecs[8];
   int          tests = 0;
   int          fails = 0;
   int          m_drops = 0;
   bit          m_ovf = 0;
   logic [31:0] m_ts = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_ev(input bit en, input bit wbv, input bit ld, input bit stv, input bit brv,
                         input logic [31:0] base);
      trace_en   = en;
      wb_valid   = wbv;
      wb_is_load = ld;
      wb_pc      = base;
      wb_instr   = {base[15:0], 16'h0033};
      wb_rd      = base[6:2] | 5'd1;
      wb_value   = base * 3 + 32'd1;
      wb_addr    = base + 32'h1000;
      st_valid   = stv;
      st_pc      = base + 32'd4;
      st_instr   = {base[15:0], 16'h0023};
      st_addr    = base + 32'h2000;
      st_data    = ~base;
      br_valid   = brv;
      br_pc      = base + 32'd8;
      br_instr   = {base[15:0], 16'h0063};
   endtask

   task automatic idle();
      wb_valid = 1'b0;
      st_valid = 1'b0;
      br_valid = 1'b0;
   endtask

   // Called just after a negedge with inputs settled; advances to the next negedge.
   task automatic cycle();
      exp_t e;
      exp_t evs[$];
      int   free;
      bit   pop;
      check("valid", {31'd0, trace_bus.trace_valid}, {31'd0, sb.size() != 0});
      if (trace_bus.trace_valid && sb.size() != 0) begin
         check("type",  {30'd0, trace_bus.trace_type}, {30'd0, sb[0].t});
         check("pc",    trace_bus.trace_pc, sb[0].pc);
         check("instr", trace_bus.trace_instr, sb[0].instr);
         check("rd",    {27'd0, trace_bus.trace_rd}, {27'd0, sb[0].rd});
         check("value", trace_bus.trace_value, sb[0].value);
         check("addr",  trace_bus.trace_addr, sb[0].addr);
`ifdef TRACE_TIMESTAMP_EN
         check("ts",    trace_bus.trace_ts, sb[0].ts);
`endif
      end
      pop  = trace_bus.trace_ready && sb.size() != 0;
      free = DEPTH - sb.size();
      if (trace_en) begin
         if (wb_valid) begin
            e = '{t: wb_is_load ? 2'd2 : 2'd0, pc: wb_pc, instr: wb_instr, rd: wb_rd,
                  value: wb_value, addr: wb_is_load ? wb_addr : 32'd0, ts: m_ts};
            evs.push_back(e);
         end
         if (st_valid) begin
            e = '{t: 2'd1, pc: st_pc, instr: st_instr, rd: 5'd0, value: st_data,
                  addr: st_addr, ts: m_ts};
            evs.push_back(e);
         end
         if (br_valid) begin
            e = '{t: 2'd3, pc: br_pc, instr: br_instr, rd: 5'd0, value: 32'd0,
                  addr: 32'd0, ts: m_ts};
            evs.push_back(e);
         end
      end
      foreach (evs[i]) begin
         if (free > 0) begin
            sb.push_back(evs[i]);
            free--;
         end else begin
            m_drops++;
            m_ovf = 1'b1;
         end
      end
      if (pop) begin
         popped.push_back(sb[0].t);
         void'(sb.pop_front());
      end
      @(posedge clk);
      m_ts++;
      #1;
      check("overflow",   {31'd0, overflow}, {31'd0, m_ovf});
      check("drop_count", {16'd0, drop_count}, m_drops);
      @(negedge clk);
   endtask

   function automatic vec_t mk(input bit en, input bit wbv, input bit ld, input bit stv,
                               input bit brv, input int n, input logic [5:0] ty);
      vec_t v;
      v = '{en: en, wbv: wbv, ld: ld, stv: stv, brv: brv, n: n, ty: ty};
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk(1, 1, 0, 0, 0, 1, {2'd0, 2'd0, 2'd0});
      vecs[1] = mk(1, 1, 1, 1, 1, 3, {2'd3, 2'd1, 2'd2});
      vecs[2] = mk(1, 0, 0, 1, 0, 1, {2'd0, 2'd0, 2'd1});
      vecs[3] = mk(1, 0, 0, 0, 1, 1, {2'd0, 2'd0, 2'd3});
      vecs[4] = mk(1, 0, 0, 1, 1, 2, {2'd0, 2'd3, 2'd1});
      vecs[5] = mk(1, 1, 0, 0, 1, 2, {2'd0, 2'd3, 2'd0});
      vecs[6] = mk(0, 1, 1, 1, 1, 0, {2'd0, 2'd0, 2'd0});
      vecs[7] = mk(1, 1, 1, 1, 0, 2, {2'd0, 2'd1, 2'd2});

      set_ev(1, 0, 0, 0, 0, 32'h0);
      trace_bus.trace_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid",    {31'd0, trace_bus.trace_valid}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_drops",    {16'd0, drop_count}, 32'd0);
      check("rst_pc",       trace_bus.trace_pc, 32'd0);
      check("rst_value",    trace_bus.trace_value, 32'd0);
      reset_n = 1'b1;
      m_ts    = 0;

      // Single write-back record, then the stream goes idle.
      trace_bus.trace_ready = 1'b1;
      set_ev(1, 1, 0, 0, 0, 32'h10);
      wb_rd    = 5'd5;
      wb_value = 32'hDEADBEEF;
      cycle();
      idle();
      check("single_valid", {31'd0, trace_bus.trace_valid}, 32'd1);
      check("single_type",  {30'd0, trace_bus.trace_type}, 32'd0);
      check("single_rd",    {27'd0, trace_bus.trace_rd}, 32'd5);
      check("single_value", trace_bus.trace_value, 32'hDEADBEEF);
      check("single_pc",    trace_bus.trace_pc, 32'h10);
      cycle();
      check("single_after", {31'd0, trace_bus.trace_valid}, 32'd0);

      for (int v = 0; v < 8; v++) begin
         popped.delete();
         set_ev(vecs[v].en, vecs[v].wbv, vecs[v].ld, vecs[v].stv, vecs[v].brv,
                32'h100 + 32'(v) * 32'h40);
         cycle();
         idle();
         trace_en = 1'b1;
         repeat (5) cycle();
         check("vec_count", popped.size(), vecs[v].n);
         for (int j = 0; j < vecs[v].n && j < popped.size(); j++) begin
            check("vec_order", {30'd0, popped[j]}, {30'd0, vecs[v].ty[2*j +: 2]});
         end
      end

      // Stalled sink: six cycles of three events overfill the FIFO.
      trace_bus.trace_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         set_ev(1, 1, c[0], 1, 1, 32'h4000 + 32'(c) * 32'h20);
         cycle();
      end
      idle();
      check("ovf_flag",  {31'd0, overflow}, 32'd1);
      check("ovf_drops", {16'd0, drop_count}, 32'd2);
      check("ovf_head",  trace_bus.trace_pc, 32'h4000);

      // Full FIFO with a pop in the same cycle: the new event is still dropped.
      trace_bus.trace_ready = 1'b1;
      set_ev(1, 1, 0, 0, 0, 32'h5000);
      cycle();
      idle();
      check("full_pop_drops", {16'd0, drop_count}, 32'd3);
      for (int i = 0; i < 20 && sb.size() > 5; i++) begin
         cycle();
      end
      check("pre_reset_valid", {31'd0, trace_bus.trace_valid}, 32'd1);

      // Asynchronous reset while five records remain queued.
      #2 reset_n = 1'b0;
      #1;
      check("midrst_valid",    {31'd0, trace_bus.trace_valid}, 32'd0);
      check("midrst_overflow", {31'd0, overflow}, 32'd0);
      check("midrst_drops",    {16'd0, drop_count}, 32'd0);
      sb.delete();
      popped.delete();
      m_drops = 0;
      m_ovf   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      m_ts    = 0;
      set_ev(1, 1, 0, 1, 0, 32'h6000);
      cycle();
      idle();
      repeat (4) cycle();
      check("post_reset_count", popped.size(), 32'd2);

`ifdef TRACE_TIMESTAMP_EN
      reset_n = 1'b0;
      sb.delete();
      m_drops = 0;
      m_ovf   = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      m_ts    = 0;
      repeat (3) cycle();
      set_ev(1, 1, 0, 0, 0, 32'h7000);
      cycle();
      idle();
      check("ts_first", trace_bus.trace_ts, 32'd3);
      repeat (3) cycle();
      set_ev(1, 1, 0, 0, 0, 32'h7100);
      cycle();
      idle();
      check("ts_second", trace_bus.trace_ts, 32'd7);
      repeat (2) cycle();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
